// File: rtl/vpu_alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : vpu_alu_seq_if
// Brief    : Command, VRF read/write and status bundle for vpu_alu_seq.
//            Mask signals exist only when VPU_ALU_SEQ_MASK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface vpu_alu_seq_if #(
    parameter int AW = 6,
    parameter int LW = 7
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [LW-1:0] cmd_vl;
    logic [AW-1:0] cmd_src1;
    logic [AW-1:0] cmd_src2;
    logic [AW-1:0] cmd_dst;
    logic          cmd_vs;
    logic [15:0]   cmd_scalar;
    logic          stall;
    logic          rd_en;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic [15:0]   rd_data1;
    logic [15:0]   rd_data2;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          done;
`ifdef VPU_ALU_SEQ_MASK_EN
    logic [(1<<LW)-1:0] cmd_mask;
    logic [LW-1:0]      mask_skips;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_vl, cmd_src1, cmd_src2, cmd_dst,
               cmd_vs, cmd_scalar, stall, rd_data1, rd_data2,
        input  cmd_ready, rd_en, rd_addr1, rd_addr2, wr_en, wr_addr,
               wr_data, busy, done
`ifdef VPU_ALU_SEQ_MASK_EN
        , output cmd_mask
        , input  mask_skips
`endif
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_vl, cmd_src1, cmd_src2, cmd_dst,
               cmd_vs, cmd_scalar, stall, rd_data1, rd_data2,
        output cmd_ready, rd_en, rd_addr1, rd_addr2, wr_en, wr_addr,
               wr_data, busy, done
`ifdef VPU_ALU_SEQ_MASK_EN
        , input  cmd_mask
        , output mask_skips
`endif
    );
endinterface
`default_nettype wire

// File: rtl/vpu_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : vpu_alu_seq
// Brief    : Vector-op sequencer streaming VRF elements through one ALU16.
//            Define VPU_ALU_SEQ_MASK_EN for per-element write masking.
// Revision : 1.0 - initial release
// ============================================================================
module vpu_alu_seq #(
    parameter int AW = 6,
    parameter int LW = 7
) (
    input  wire logic    clk,
    input  wire logic    rst,
    vpu_alu_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [3:0]    r_op;
    logic          r_vs;
    logic [15:0]   r_scalar;
    logic [AW-1:0] r_src1;
    logic [AW-1:0] r_src2;
    logic [AW-1:0] r_dst;
    logic [LW-1:0] r_vl;
    logic [LW-1:0] r_idx;
    logic          r_ex_valid;
    logic [LW-1:0] r_ex_idx;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [15:0]   r_wr_data;

    logic          w_accept;
    logic          w_rd_en;
    logic [LW-1:0] w_idx_next;
    logic          w_keep;
    logic [15:0]   w_ds1;
    logic [15:0]   w_ds2;
    logic [3:0]    w_shamt;
    logic          w_enable;
    logic          w_addsel, w_subsel, w_andsel, w_orsel, w_xorsel;
    logic          w_sllsel, w_srlsel, w_srasel, w_maxsel, w_minsel;
    logic [15:0]   w_result;

    assign w_accept   = bus.cmd_valid && (r_state == S_IDLE);
    assign w_rd_en    = (r_state == S_ISSUE) && !bus.stall;
    assign w_idx_next = r_idx + LW'(1);

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr1  = w_rd_en ? AW'(r_src1 + AW'(r_idx)) : '0;
    assign bus.rd_addr2  = w_rd_en ? AW'(r_src2 + AW'(r_idx)) : '0;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;

    // Execute stage: read data arrives one cycle after rd_en
    assign w_ds1   = bus.rd_data1;
    assign w_ds2   = r_vs ? r_scalar : bus.rd_data2;
    assign w_shamt = w_ds2[3:0];

    always_comb begin
        w_enable = 1'b1;
        w_addsel = 1'b0; w_subsel = 1'b0; w_andsel = 1'b0; w_orsel  = 1'b0;
        w_xorsel = 1'b0; w_sllsel = 1'b0; w_srlsel = 1'b0; w_srasel = 1'b0;
        w_maxsel = 1'b0; w_minsel = 1'b0;
        case (r_op)
            4'd1:    w_addsel = 1'b1;
            4'd2:    w_subsel = 1'b1;
            4'd3:    w_andsel = 1'b1;
            4'd4:    w_orsel  = 1'b1;
            4'd5:    w_xorsel = 1'b1;
            4'd6:    w_sllsel = 1'b1;
            4'd7:    w_srlsel = 1'b1;
            4'd8:    w_srasel = 1'b1;
            4'd9:    w_maxsel = 1'b1;
            4'd10:   w_minsel = 1'b1;
            default: w_enable = 1'b0;
        endcase
    end

    // ALU16 datapath: one-hot selects OR-combined; disabled ALU passes ds1
    always_comb begin
        w_result = ({16{w_addsel}} & 16'(w_ds1 + w_ds2))
                 | ({16{w_subsel}} & 16'(w_ds1 - w_ds2))
                 | ({16{w_andsel}} & (w_ds1 & w_ds2))
                 | ({16{w_orsel}}  & (w_ds1 | w_ds2))
                 | ({16{w_xorsel}} & (w_ds1 ^ w_ds2))
                 | ({16{w_sllsel}} & 16'(w_ds1 << w_shamt))
                 | ({16{w_srlsel}} & 16'(w_ds1 >> w_shamt))
                 | ({16{w_srasel}} & 16'($signed(w_ds1) >>> w_shamt))
                 | ({16{w_maxsel}} & (($signed(w_ds1) > $signed(w_ds2)) ? w_ds1 : w_ds2))
                 | ({16{w_minsel}} & (($signed(w_ds1) < $signed(w_ds2)) ? w_ds1 : w_ds2));
        if (!w_enable) begin
            w_result = w_ds1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_vs       <= 1'b0;
            r_scalar   <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_dst      <= '0;
            r_vl       <= '0;
            r_idx      <= '0;
            r_ex_valid <= 1'b0;
            r_ex_idx   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_ex_valid <= w_rd_en;
            r_ex_idx   <= r_idx;
            r_wr_en    <= r_ex_valid && w_keep;
            if (r_ex_valid) begin
                r_wr_addr <= AW'(r_dst + AW'(r_ex_idx));
                r_wr_data <= w_result;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= bus.cmd_op;
                        r_vs     <= bus.cmd_vs;
                        r_scalar <= bus.cmd_scalar;
                        r_src1   <= bus.cmd_src1;
                        r_src2   <= bus.cmd_src2;
                        r_dst    <= bus.cmd_dst;
                        r_vl     <= bus.cmd_vl;
                        r_idx    <= '0;
                        r_state  <= (bus.cmd_vl == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_rd_en) begin
                        r_idx <= w_idx_next;
                        if (w_idx_next == r_vl) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                // Last element has left execute once no read is pending there
                S_DRAIN: begin
                    if (!r_ex_valid) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef VPU_ALU_SEQ_MASK_EN
    logic [(1<<LW)-1:0] r_mask;
    logic [LW-1:0]      r_skips;

    assign w_keep         = r_mask[r_ex_idx];
    assign bus.mask_skips = r_skips;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask  <= '0;
            r_skips <= '0;
        end else if (w_accept) begin
            r_mask  <= bus.cmd_mask;
            r_skips <= '0;
        end else if (r_ex_valid && !w_keep) begin
            r_skips <= r_skips + LW'(1);
        end
    end
`else
    assign w_keep = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vpu_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vpu_alu_seq
// Brief    : Directed self-checking bench for vpu_alu_seq with a VRF responder
//            and an element-level reference model. Honours VPU_ALU_SEQ_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vpu_alu_seq;
    logic clk;
    logic rst;

    vpu_alu_seq_if #(.AW(6), .LW(7)) bus ();

    vpu_alu_seq #(.AW(6), .LW(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int rel; logic [5:0] a1; logic [5:0] a2; } rd_t;
    typedef struct { int rel; logic [5:0] addr; logic [15:0] data; } wr_t;

    logic [15:0] mem [64];
    rd_t         exp_rd[$];
    wr_t         exp_wr[$];
    int          log_rd_rel[$];
    wr_t         log_wr[$];
    int          log_done_rel;
    int          exp_done_rel;
    int          exp_ready_rel;
    int          exp_busy_lim;
    int          exp_skips;
    int          cyc;
    int          acc_cyc;
    bit          active;
    int          checks;
    int          failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc - acc_cyc);
        end
    endtask

    function automatic logic [15:0] model_alu(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << b[3:0];
            4'd7:    return a >> b[3:0];
            4'd8:    return 16'($signed(a) >>> b[3:0]);
            4'd9:    return ($signed(a) > $signed(b)) ? a : b;
            4'd10:   return ($signed(a) < $signed(b)) ? a : b;
            default: return a;
        endcase
    endfunction

    // VRF: data for a read sampled in cycle n is presented throughout cycle n+1
    initial begin
        logic       p;
        logic [5:0] a1, a2;
        bus.rd_data1 = 16'hDEAD;
        bus.rd_data2 = 16'hDEAD;
        forever begin
            @(negedge clk);
            p  = bus.rd_en;
            a1 = bus.rd_addr1;
            a2 = bus.rd_addr2;
            @(posedge clk);
            #1;
            bus.rd_data1 = p ? mem[a1] : 16'hDEAD;
            bus.rd_data2 = p ? mem[a2] : 16'hBEEF;
        end
    end

    // Compare process: every observable output, each cycle of a command
    initial begin
        int  rel;
        rd_t er;
        wr_t ew;
        forever begin
            @(negedge clk);
            if (active) begin
                rel = cyc - acc_cyc;
                if (bus.rd_en) begin
                    log_rd_rel.push_back(rel);
                    if (exp_rd.size() == 0) chk("unexpected_rd", 1, 0);
                    else begin
                        er = exp_rd.pop_front();
                        chk("rd_cycle", rel, er.rel);
                        chk("rd_addr1", bus.rd_addr1, er.a1);
                        chk("rd_addr2", bus.rd_addr2, er.a2);
                    end
                end
                if (bus.wr_en) begin
                    log_wr.push_back('{rel, bus.wr_addr, bus.wr_data});
                    if (exp_wr.size() == 0) chk("unexpected_wr", 1, 0);
                    else begin
                        ew = exp_wr.pop_front();
                        chk("wr_cycle", rel, ew.rel);
                        chk("wr_addr", bus.wr_addr, ew.addr);
                        chk("wr_data", bus.wr_data, ew.data);
                    end
                end
                if (bus.done) log_done_rel = rel;
                if (bus.done || rel == exp_done_rel) begin
                    chk("done_pulse", bus.done, rel == exp_done_rel);
`ifdef VPU_ALU_SEQ_MASK_EN
                    chk("mask_skips", bus.mask_skips, exp_skips);
`endif
                end
                chk("busy", bus.busy, (rel >= 1) && (rel < exp_busy_lim));
                if (rel == exp_ready_rel) chk("ready_after", bus.cmd_ready, 1);
                if (rel >= 1 && rel == exp_ready_rel - 1) chk("ready_low", bus.cmd_ready, 0);
            end
        end
    end

    task automatic run_cmd(input logic [3:0] op, input int vl, input logic [5:0] s1,
                           input logic [5:0] s2, input logic [5:0] d, input bit vs,
                           input logic [15:0] sc, input logic [127:0] mask,
                           input logic [31:0] spat, input int rst_rel);
        int  r, last;
        bit  keep;
        exp_rd.delete();
        exp_wr.delete();
        log_rd_rel.delete();
        log_wr.delete();
        log_done_rel = -1;
        exp_skips    = 0;
        r    = 1;
        last = 0;
        for (int k = 0; k < vl; k++) begin
            while (r < 32 && spat[r]) r++;
`ifdef VPU_ALU_SEQ_MASK_EN
            keep = mask[k];
`else
            keep = 1'b1;
`endif
            if (!keep) exp_skips++;
            if (rst_rel < 0 || r <= rst_rel)
                exp_rd.push_back('{r, 6'(s1 + k), 6'(s2 + k)});
            if (keep && (rst_rel < 0 || r + 2 <= rst_rel))
                exp_wr.push_back('{r + 2, 6'(d + k),
                                   model_alu(op, mem[6'(s1 + k)], vs ? sc : mem[6'(s2 + k)])});
            last = r;
            r++;
        end
        if (rst_rel >= 0) begin
            exp_done_rel  = -100;
            exp_ready_rel = rst_rel + 1;
            exp_busy_lim  = rst_rel + 1;
        end else begin
            exp_done_rel  = (vl == 0) ? 1 : last + 3;
            exp_ready_rel = exp_done_rel + 1;
            exp_busy_lim  = exp_done_rel;
        end

        @(posedge clk);
        #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_vl     = 7'(vl);
        bus.cmd_src1   = s1;
        bus.cmd_src2   = s2;
        bus.cmd_dst    = d;
        bus.cmd_vs     = vs;
        bus.cmd_scalar = sc;
`ifdef VPU_ALU_SEQ_MASK_EN
        bus.cmd_mask   = mask;
`endif
        bus.stall      = spat[0];
        acc_cyc        = cyc;
        active         = 1'b1;
        chk("ready_at_accept", bus.cmd_ready, 1);
        for (int c = 1; c <= exp_ready_rel + 2; c++) begin
            @(posedge clk);
            #1;
            // Garbage on the command port after capture must have no effect
            bus.cmd_valid  = (c == 2) && (exp_ready_rel > 2);
            bus.cmd_op     = 4'($urandom);
            bus.cmd_vl     = 7'($urandom);
            bus.cmd_src1   = 6'($urandom);
            bus.cmd_src2   = 6'($urandom);
            bus.cmd_dst    = 6'($urandom);
            bus.cmd_vs     = 1'($urandom);
            bus.cmd_scalar = 16'($urandom);
            bus.stall      = (c < 32) ? spat[c] : 1'b0;
            rst            = (c == rst_rel);
        end
        active = 1'b0;
        bus.stall = 1'b0;
        chk("missing_rd", exp_rd.size(), 0);
        chk("missing_wr", exp_wr.size(), 0);
    endtask

    task automatic log_wr_is(input int idx, input int rel, input logic [5:0] addr,
                             input logic [15:0] data);
        if (idx < log_wr.size()) begin
            chk("lit_wr_cycle", log_wr[idx].rel, rel);
            chk("lit_wr_addr", log_wr[idx].addr, addr);
            chk("lit_wr_data", log_wr[idx].data, data);
        end else begin
            chk("lit_wr_count", log_wr.size(), idx + 1);
        end
    endtask

    localparam logic [127:0] ALL = {128{1'b1}};

    initial begin
        checks = 0;
        failures = 0;
        active = 1'b0;
        acc_cyc = 0;
        exp_done_rel = -100;
        exp_ready_rel = -100;
        exp_busy_lim = 0;
        exp_skips = 0;
        log_done_rel = -1;
        for (int i = 0; i < 64; i++) mem[i] = 16'((i * 16'h1357) ^ 16'hA5A5);
        for (int i = 0; i < 4; i++) begin
            mem[i]     = 16'(i + 1);
            mem[8 + i] = 16'(10 * (i + 1));
        end
        mem[20] = 16'h0000; mem[21] = 16'h8000;
        mem[24] = 16'h8000; mem[25] = 16'h0004;
        mem[26] = 16'hFFFF; mem[27] = 16'h0001;

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_vl = '0; bus.cmd_src1 = '0;
        bus.cmd_src2 = '0; bus.cmd_dst = '0; bus.cmd_vs = 1'b0; bus.cmd_scalar = '0;
        bus.stall = 1'b0;
`ifdef VPU_ALU_SEQ_MASK_EN
        bus.cmd_mask = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_rd_addr1", bus.rd_addr1, 0);
        chk("rst_rd_addr2", bus.rd_addr2, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_cmd(4'd1, 4, 6'd0, 6'd8, 6'd16, 1'b0, 16'h0, ALL, 32'h0, -1);
        log_wr_is(0, 3, 6'd16, 16'd11);
        log_wr_is(1, 4, 6'd17, 16'd22);
        log_wr_is(2, 5, 6'd18, 16'd33);
        log_wr_is(3, 6, 6'd19, 16'd44);
        chk("lit_add_done", log_done_rel, 7);

        run_cmd(4'd2, 2, 6'd20, 6'd0, 6'd30, 1'b1, 16'h0001, ALL, 32'h0, -1);
        log_wr_is(0, 3, 6'd30, 16'hFFFF);
        log_wr_is(1, 4, 6'd31, 16'h7FFF);

        run_cmd(4'd8, 1, 6'd24, 6'd25, 6'd40, 1'b0, 16'h0, ALL, 32'h0, -1);
        log_wr_is(0, 3, 6'd40, 16'hF800);
        run_cmd(4'd7, 1, 6'd24, 6'd25, 6'd40, 1'b0, 16'h0, ALL, 32'h0, -1);
        log_wr_is(0, 3, 6'd40, 16'h0800);
        run_cmd(4'd9, 1, 6'd26, 6'd27, 6'd40, 1'b0, 16'h0, ALL, 32'h0, -1);
        log_wr_is(0, 3, 6'd40, 16'h0001);

        run_cmd(4'd5, 3, 6'd44, 6'd50, 6'd5, 1'b0, 16'h0, ALL, 32'h0000_000C, -1);
        chk("lit_stall_rd_count", log_rd_rel.size(), 3);
        if (log_rd_rel.size() == 3) begin
            chk("lit_stall_rd0", log_rd_rel[0], 1);
            chk("lit_stall_rd1", log_rd_rel[1], 4);
            chk("lit_stall_rd2", log_rd_rel[2], 5);
        end
        chk("lit_stall_wr_count", log_wr.size(), 3);
        if (log_wr.size() == 3) begin
            chk("lit_stall_wr0", log_wr[0].rel, 3);
            chk("lit_stall_wr1", log_wr[1].rel, 6);
            chk("lit_stall_wr2", log_wr[2].rel, 7);
        end
        chk("lit_stall_done", log_done_rel, 8);

        run_cmd(4'd4, 3, 6'd2, 6'd12, 6'd62, 1'b0, 16'h0, ALL, 32'h0, -1);
        chk("lit_wrap_count", log_wr.size(), 3);
        if (log_wr.size() == 3) begin
            chk("lit_wrap_a0", log_wr[0].addr, 62);
            chk("lit_wrap_a1", log_wr[1].addr, 63);
            chk("lit_wrap_a2", log_wr[2].addr, 0);
        end

        run_cmd(4'd1, 0, 6'd0, 6'd8, 6'd16, 1'b0, 16'h0, ALL, 32'h0, -1);
        chk("lit_vl0_rd", log_rd_rel.size(), 0);
        chk("lit_vl0_wr", log_wr.size(), 0);
        chk("lit_vl0_done", log_done_rel, 1);

        run_cmd(4'd3, 8, 6'd30, 6'd40, 6'd50, 1'b0, 16'h0, ALL, 32'h0, 2);
        chk("lit_rst_wr", log_wr.size(), 0);
        chk("lit_rst_done", log_done_rel, -1);

        run_cmd(4'd6, 5, 6'd60, 6'd3, 6'd33, 1'b1, 16'h0013, ALL, 32'h0000_0003, -1);
        run_cmd(4'd10, 5, 6'd40, 6'd20, 6'd10, 1'b0, 16'h0, ALL, 32'h0000_0054, -1);
        run_cmd(4'd0, 4, 6'd24, 6'd26, 6'd0, 1'b0, 16'h0, ALL, 32'h0, -1);
        run_cmd(4'd13, 3, 6'd8, 6'd0, 6'd60, 1'b1, 16'h1234, ALL, 32'h0000_0020, -1);
        run_cmd(4'd2, 127, 6'd5, 6'd37, 6'd17, 1'b0, 16'h0, ALL, 32'h0, -1);

`ifdef VPU_ALU_SEQ_MASK_EN
        run_cmd(4'd1, 4, 6'd0, 6'd8, 6'd20, 1'b0, 16'h0, 128'b0101, 32'h0, -1);
        chk("lit_mask_count", log_wr.size(), 2);
        log_wr_is(0, 3, 6'd20, 16'd11);
        log_wr_is(1, 5, 6'd22, 16'd33);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
